// File: rtl/bist_pkg.sv
// Shared types and helpers for the benchmark BIST controller.
//   state_t    : controller FSM states
//   DEF_*      : default polynomial and seed constants (32-bit bench CUT)
//   lfsr_step  : one Galois right-shift step, s' = (s >> 1) ^ (s[0] ? poly : 0).
//                Operates on MAX_WIDTH bits; callers zero-extend and truncate,
//                which is exact because the shift only moves bits downward.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          MAX_WIDTH     = 64;
    localparam logic [31:0] DEF_POLY      = 32'h8020_0003;
    localparam logic [31:0] DEF_LFSR_SEED = 32'h0000_0001;
    localparam logic [31:0] DEF_MISR_SEED = 32'h0000_0000;

    function automatic logic [MAX_WIDTH-1:0] lfsr_step(input logic [MAX_WIDTH-1:0] s,
                                                       input logic [MAX_WIDTH-1:0] poly);
        return (s >> 1) ^ (s[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Galois LFSR / MISR register. With din tied to zero it is a pattern
// generator; with din driven by the CUT response it compacts a signature.
//   clk, rst_n : clock, asynchronous active-low reset (q <= SEED)
//   load       : q <= load_val (has priority over en)
//   load_val   : value loaded on load
//   en         : q <= step(q) ^ din
//   din        : data folded into the register on each enabled step
//   q          : register contents
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_LFSR_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= WIDTH'(lfsr_step(MAX_WIDTH'(q), MAX_WIDTH'(POLY))) ^ din;
        end
    end

endmodule

// File: rtl/bench_bist_ctrl.sv
// BIST controller for a combinational benchmark CUT: drives LFSR vectors
// onto cut_in, compacts cut_out into a MISR signature, and compares the
// final signature against golden.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, abort     : begin a run (IDLE/DONE only) / cancel an active run
//   seed_ld, seed_i  : optional run-time generator seed (zero -> LFSR_SEED)
//   golden           : expected signature
//   cut_in, cut_out  : CUT stimulus / response
//   busy, done, pass : run status; pass valid while done=1
//   signature        : MISR value
//
// state | meaning
// IDLE  | waiting for start after reset or abort
// RUN   | issuing one vector per cycle, PATTERNS in total
// FLUSH | no new vectors; waiting for in-flight CUT responses (CUT_LAT>0)
// DONE  | signature final, pass registered; waiting for start
module bench_bist_ctrl
    import bist_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               PATTERNS  = 1024,
    parameter int               CUT_LAT   = 0,
    parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(DEF_LFSR_SEED),
    parameter logic [WIDTH-1:0] MISR_SEED = WIDTH'(DEF_MISR_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             seed_ld,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [WIDTH-1:0] golden,
    output logic [WIDTH-1:0] cut_in,
    input  logic [WIDTH-1:0] cut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int CW = $clog2(PATTERNS + 1);

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic             issue, start_ok, abort_act, last_issue, flush_last;
    logic             gen_en, misr_load, finishing;
    logic [CUT_LAT:0] vld;
    logic [WIDTH-1:0] gen_seed, gen_din, misr_next;

    assign start_ok   = start && !abort && (state == IDLE || state == DONE);
    assign abort_act  = abort && (state == RUN || state == FLUSH);
    assign last_issue = (count == CW'(PATTERNS - 1));
    assign gen_seed   = (seed_ld && seed_i != '0) ? seed_i : LFSR_SEED;
    assign gen_din    = '0;
    assign gen_en     = issue && !abort;
    assign misr_load  = start_ok || abort_act;
    assign misr_next  = WIDTH'(lfsr_step(MAX_WIDTH'(signature), MAX_WIDTH'(LFSR_POLY))) ^ cut_out;
    assign finishing  = (state == RUN || state == FLUSH) && state_next == DONE;

    // vld[0] tags the vector currently on cut_in; vld[CUT_LAT] marks the
    // cycle whose cut_out belongs to a real vector and must be compacted.
    generate
        if (CUT_LAT > 0) begin : g_pipe
            logic [CUT_LAT-1:0] vld_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                end else if (abort_act) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld[CUT_LAT-1:0];
                end
            end
            assign vld        = {vld_q, issue};
            assign flush_last = vld[CUT_LAT] && !(|vld[CUT_LAT-1:0]);
        end else begin : g_nopipe
            assign vld        = issue;
            assign flush_last = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = RUN;
            RUN: begin
                if (abort)           state_next = IDLE;
                else if (last_issue) state_next = (CUT_LAT > 0) ? FLUSH : DONE;
            end
            FLUSH: begin
                if (abort)           state_next = IDLE;
                else if (flush_last) state_next = DONE;
            end
            DONE:    if (start_ok) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        issue = 1'b0;
        case (state)
            RUN:     begin busy = 1'b1; issue = 1'b1; end
            FLUSH:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (start_ok) begin
            count <= '0;
        end else if (gen_en) begin
            count <= count + CW'(1);
        end
    end

    // pass is captured once on the DONE entry edge so later golden changes
    // cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else if (start_ok || abort_act) begin
            pass <= 1'b0;
        end else if (finishing) begin
            pass <= (misr_next == golden);
        end
    end

    bist_lfsr #(.WIDTH(WIDTH), .POLY(LFSR_POLY), .SEED(LFSR_SEED)) u_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_ok),
        .load_val (gen_seed),
        .en       (gen_en),
        .din      (gen_din),
        .q        (cut_in)
    );

    bist_lfsr #(.WIDTH(WIDTH), .POLY(LFSR_POLY), .SEED(MISR_SEED)) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (misr_load),
        .load_val (MISR_SEED),
        .en       (vld[CUT_LAT]),
        .din      (cut_out),
        .q        (signature)
    );

endmodule

// File: tb/tb_bench_bist_ctrl.sv
// Self-checking bench for bench_bist_ctrl. Four instances cover
// PATTERNS/CUT_LAT corners: (1,0) zero response, (2,0) all-ones response,
// (4,2) loopback through two bench pipe registers, (1024,0) cut_in ^ XK.
// Expected run results are pushed to a scoreboard when a run is started and
// popped when the instance raises done.
module tb_bench_bist_ctrl;

    localparam logic [31:0] XK = 32'h5A5A_5A5A;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start_a[4], abort_a[4], seed_ld_a[4], busy_a[4], done_a[4], pass_a[4];
    logic [31:0] seed_a[4], golden_a[4], cut_in_a[4], cut_out_a[4], sig_a[4];
    logic [31:0] p1, p2;

    assign cut_out_a[0] = 32'h0;
    assign cut_out_a[1] = 32'hFFFF_FFFF;
    assign cut_out_a[2] = p2;
    assign cut_out_a[3] = cut_in_a[3] ^ XK;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= '0;
            p2 <= '0;
        end else begin
            p1 <= cut_in_a[2];
            p2 <= p1;
        end
    end

    bench_bist_ctrl #(.PATTERNS(1), .CUT_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .abort(abort_a[0]),
        .seed_ld(seed_ld_a[0]), .seed_i(seed_a[0]), .golden(golden_a[0]),
        .cut_in(cut_in_a[0]), .cut_out(cut_out_a[0]), .busy(busy_a[0]),
        .done(done_a[0]), .pass(pass_a[0]), .signature(sig_a[0]));

    bench_bist_ctrl #(.PATTERNS(2), .CUT_LAT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .abort(abort_a[1]),
        .seed_ld(seed_ld_a[1]), .seed_i(seed_a[1]), .golden(golden_a[1]),
        .cut_in(cut_in_a[1]), .cut_out(cut_out_a[1]), .busy(busy_a[1]),
        .done(done_a[1]), .pass(pass_a[1]), .signature(sig_a[1]));

    bench_bist_ctrl #(.PATTERNS(4), .CUT_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .abort(abort_a[2]),
        .seed_ld(seed_ld_a[2]), .seed_i(seed_a[2]), .golden(golden_a[2]),
        .cut_in(cut_in_a[2]), .cut_out(cut_out_a[2]), .busy(busy_a[2]),
        .done(done_a[2]), .pass(pass_a[2]), .signature(sig_a[2]));

    bench_bist_ctrl #(.PATTERNS(1024), .CUT_LAT(0)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_a[3]), .abort(abort_a[3]),
        .seed_ld(seed_ld_a[3]), .seed_i(seed_a[3]), .golden(golden_a[3]),
        .cut_in(cut_in_a[3]), .cut_out(cut_out_a[3]), .busy(busy_a[3]),
        .done(done_a[3]), .pass(pass_a[3]), .signature(sig_a[3]));

    typedef struct {
        int          idx;
        logic [31:0] sig;
        logic        pass;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tb_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Reference signature for instance idx: each vector's response is
    // folded into the MISR exactly once, in issue order.
    function automatic logic [31:0] model_sig(input int idx, input logic [31:0] seed, input int n);
        logic [31:0] v, m, co;
        v = seed;
        m = 32'h0;
        for (int k = 0; k < n; k++) begin
            case (idx)
                0:       co = 32'h0;
                1:       co = 32'hFFFF_FFFF;
                2:       co = v;
                default: co = v ^ XK;
            endcase
            m = tb_step(m) ^ co;
            v = tb_step(v);
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_run(input int idx, input logic [31:0] eff_seed, input int n,
                              input logic [31:0] gold);
        exp_t e;
        golden_a[idx] = gold;
        e.idx  = idx;
        e.sig  = model_sig(idx, eff_seed, n);
        e.pass = (e.sig == gold);
        sb.push_back(e);
    endtask

    task automatic start_run(input int idx, input logic ld, input logic [31:0] seed);
        seed_ld_a[idx] = ld;
        seed_a[idx]    = seed;
        start_a[idx]   = 1'b1;
        tick();
        start_a[idx]   = 1'b0;
        seed_ld_a[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int budget, output int cyc);
        exp_t e;
        cyc = 0;
        while (!done_a[idx] && cyc < budget) begin
            tick();
            cyc++;
        end
        chk("done_seen", {31'b0, done_a[idx]}, 32'h1);
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_empty: got no expected entry for instance %0d", idx);
        end else begin
            e = sb.pop_front();
            chk("signature", sig_a[idx], e.sig);
            chk("pass", {31'b0, pass_a[idx]}, {31'b0, e.pass});
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] ref2, ref_d, ref3, v;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_a[i]   = 1'b0;
            abort_a[i]   = 1'b0;
            seed_ld_a[i] = 1'b0;
            seed_a[i]    = '0;
            golden_a[i]  = '0;
        end
        repeat (3) tick();
        chk("rst_busy", {31'b0, busy_a[2]}, 32'h0);
        chk("rst_done", {31'b0, done_a[2]}, 32'h0);
        chk("rst_pass", {31'b0, pass_a[2]}, 32'h0);
        chk("rst_cut_in", cut_in_a[2], 32'h1);
        chk("rst_sig", sig_a[2], 32'h0);
        rst_n = 1'b1;
        tick();

        // PATTERNS=1, zero response
        expect_run(0, 32'h1, 1, 32'h0);
        start_run(0, 1'b0, 32'h0);
        chk("t1_busy", {31'b0, busy_a[0]}, 32'h1);
        chk("t1_done0", {31'b0, done_a[0]}, 32'h0);
        wait_done(0, 10, cyc);
        chk("t1_lat", cyc, 1);
        chk("t1_busy_end", {31'b0, busy_a[0]}, 32'h0);

        // PATTERNS=2, all-ones response
        expect_run(1, 32'h1, 2, 32'h0020_0003);
        start_run(1, 1'b0, 32'h0);
        tick();
        chk("t2_sig_e1", sig_a[1], 32'hFFFF_FFFF);
        wait_done(1, 10, cyc);
        chk("t2_lat", cyc, 1);
        chk("t2_sig_lit", sig_a[1], 32'h0020_0003);

        // PATTERNS=4, CUT_LAT=2 loopback
        ref2 = model_sig(2, 32'h1, 4);
        expect_run(2, 32'h1, 4, ref2);
        start_run(2, 1'b0, 32'h0);
        v = 32'h1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_cut_in", cut_in_a[2], v);
            chk("t3_busy", {31'b0, busy_a[2]}, 32'h1);
            v = tb_step(v);
            tick();
        end
        wait_done(2, 10, cyc);
        chk("t3_lat", cyc + 4, 6);

        // golden off by one bit, then rerun from DONE
        expect_run(2, 32'h1, 4, ref2 ^ 32'h1);
        start_run(2, 1'b0, 32'h0);
        wait_done(2, 20, cyc);
        expect_run(2, 32'h1, 4, ref2);
        start_run(2, 1'b0, 32'h0);
        chk("t6_done_drop", {31'b0, done_a[2]}, 32'h0);
        chk("t6_pass_drop", {31'b0, pass_a[2]}, 32'h0);
        wait_done(2, 20, cyc);
        golden_a[2] = ~ref2;
        tick();
        chk("t6_pass_hold", {31'b0, pass_a[2]}, 32'h1);

        // run-time seeds
        expect_run(2, 32'h1, 4, ref2);
        start_run(2, 1'b1, 32'h0);
        chk("t4_seed0", cut_in_a[2], 32'h1);
        wait_done(2, 20, cyc);
        ref_d = model_sig(2, 32'hDEAD_BEEF, 4);
        expect_run(2, 32'hDEAD_BEEF, 4, ref_d);
        start_run(2, 1'b1, 32'hDEAD_BEEF);
        chk("t4_seed", cut_in_a[2], 32'hDEAD_BEEF);
        wait_done(2, 20, cyc);

        // 1024-pattern run: ignored mid-run start, abort, abort while idle
        start_run(3, 1'b0, 32'h0);
        start_a[3] = 1'b1; seed_ld_a[3] = 1'b1; seed_a[3] = 32'hDEAD_BEEF;
        tick();
        start_a[3] = 1'b0; seed_ld_a[3] = 1'b0;
        chk("t5_start_ignored", cut_in_a[3], tb_step(32'h1));
        tick();
        abort_a[3] = 1'b1; start_a[3] = 1'b1;
        tick();
        abort_a[3] = 1'b0; start_a[3] = 1'b0;
        chk("t5_abort_busy", {31'b0, busy_a[3]}, 32'h0);
        chk("t5_abort_done", {31'b0, done_a[3]}, 32'h0);
        chk("t5_abort_sig", sig_a[3], 32'h0);
        abort_a[3] = 1'b1;
        tick();
        abort_a[3] = 1'b0;
        chk("t5_idle_abort", {31'b0, busy_a[3] | done_a[3]}, 32'h0);

        ref3 = model_sig(3, 32'h1, 1024);
        expect_run(3, 32'h1, 1024, ref3);
        start_run(3, 1'b0, 32'h0);
        wait_done(3, 1100, cyc);
        chk("t5_lat", cyc, 1024);
        abort_a[3] = 1'b1;
        tick();
        abort_a[3] = 1'b0;
        chk("t5_done_abort", {31'b0, done_a[3]}, 32'h1);
        chk("t5_done_sig", sig_a[3], ref3);

        // asynchronous reset mid-run
        start_run(3, 1'b0, 32'h0);
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", {31'b0, busy_a[3]}, 32'h0);
        chk("t5_rst_done", {31'b0, done_a[3]}, 32'h0);
        chk("t5_rst_pass", {31'b0, pass_a[3]}, 32'h0);
        chk("t5_rst_cut_in", cut_in_a[3], 32'h1);
        chk("t5_rst_sig", sig_a[3], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
